io_bus_master: RTL and testbench

//  Initiator for the shared memory-mapped I/O bus (aBus/dBus/wrtEn) that the timer,
//  key, switch and LED devices respond on. Accepts one load/store at a time from
//  the processor memory stage, runs the bus cycle and returns read data with a
//  one-cycle response pulse. Sole driver of aBus and wrtEn; drives dBus only on writes.

---
 rtl/io_bus_pkg.sv | 24 ++
 rtl/io_bus_master.sv | 137 +++++++++++++
 tb/tb_io_bus_master.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// io_bus_pkg
//   Shared definitions for the memory-mapped I/O bus: the master's state
//   encoding, the device address map and the I/O window decode helper.
package io_bus_pkg;

  typedef enum logic [2:0] {
    BUS_IDLE   = 3'd0,
    BUS_SETUP  = 3'd1,
    BUS_STROBE = 3'd2,
    BUS_WAIT   = 3'd3,
    BUS_RESP   = 3'd4
  } bus_state_e;

  localparam logic [31:0] IO_BASE        = 32'hF000_0000;
  localparam logic [31:0] IO_LIMIT       = 32'hF000_03FF;
  localparam logic [31:0] TIMER_CNT_ADDR = 32'hF000_0020;
  localparam logic [31:0] TIMER_LIM_ADDR = 32'hF000_0024;
  localparam logic [31:0] TIMER_CTL_ADDR = 32'hF000_0120;

  function automatic logic addr_in_io(input logic [31:0] addr);
    return (addr >= IO_BASE) && (addr <= IO_LIMIT);
  endfunction

endpackage

// File: rtl/io_bus_master.sv
// io_bus_master
//   Initiator for the shared aBus/dBus/wrtEn I/O bus. Takes one load/store at
//   a time from the memory stage, runs the bus cycle and returns a one-cycle
//   response pulse with load data.
//   Optional feature macro: IO_BUS_MASTER_DECODE_ERR_EN -- requests outside the
//   I/O window skip the bus cycle and respond at once with resp_err=1.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     req_valid/req_ready   request handshake (ready only in IDLE)
//     req_we                1 = store, 0 = load
//     req_addr, req_wdata   target address, store data
//     resp_valid            one-cycle completion pulse
//     resp_rdata, resp_err  load data / decode error, valid with resp_valid
//     aBus, dBus, wrtEn     shared bus; dBus is 'z unless a store is driving it
//
//   state  | meaning
//   IDLE   | ready for a request, bus parked on IDLE_ADDR
//   SETUP  | address (and store data) settle, no strobe
//   STROBE | wrtEn high for exactly this cycle
//   WAIT   | load: count down, sample dBus when the counter hits 0
//   RESP   | resp_valid pulse, bus released
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int ABUS_WIDTH  = 32,
  parameter int DBUS_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1,
  parameter logic [ABUS_WIDTH-1:0] IDLE_ADDR = ABUS_WIDTH'(32'hFFFF_FFFC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ABUS_WIDTH-1:0] req_addr,
  input  logic [DBUS_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DBUS_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ABUS_WIDTH-1:0] aBus,
  inout  wire  [DBUS_WIDTH-1:0] dBus,
  output logic                  wrtEn
);

  localparam logic [2:0] ST_IDLE   = BUS_IDLE;
  localparam logic [2:0] ST_SETUP  = BUS_SETUP;
  localparam logic [2:0] ST_STROBE = BUS_STROBE;
  localparam logic [2:0] ST_WAIT   = BUS_WAIT;
  localparam logic [2:0] ST_RESP   = BUS_RESP;

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  logic [2:0]            r_state;
  logic                  r_we;
  logic [ABUS_WIDTH-1:0] r_addr;
  logic [DBUS_WIDTH-1:0] r_wdata;
  logic [DBUS_WIDTH-1:0] r_rdata;
  logic [CNT_W-1:0]      r_cnt;
`ifdef IO_BUS_MASTER_DECODE_ERR_EN
  logic                  r_err;
`endif

  logic w_bus_active;
  logic w_dbus_oe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
`ifdef IO_BUS_MASTER_DECODE_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
`ifdef IO_BUS_MASTER_DECODE_ERR_EN
            // Out-of-window requests never touch the bus.
            r_err   <= !addr_in_io(32'(req_addr));
            r_state <= addr_in_io(32'(req_addr)) ? ST_SETUP : ST_RESP;
`else
            r_state <= ST_SETUP;
`endif
          end
        end
        ST_SETUP: begin
          if (r_we) begin
            r_state <= ST_STROBE;
          end else begin
            r_cnt   <= CNT_INIT;
            r_state <= ST_WAIT;
          end
        end
        ST_STROBE: r_state <= ST_RESP;
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata <= dBus;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // All bus controls decode straight from the state register so wrtEn and
  // the dBus enable cannot glitch against aBus.
  assign w_bus_active = (r_state == ST_SETUP) || (r_state == ST_STROBE) ||
                        (r_state == ST_WAIT);
  assign w_dbus_oe    = r_we && ((r_state == ST_SETUP) || (r_state == ST_STROBE));

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign aBus       = w_bus_active ? r_addr : IDLE_ADDR;
  assign wrtEn      = (r_state == ST_STROBE);
  assign dBus       = w_dbus_oe ? r_wdata : 'z;

`ifdef IO_BUS_MASTER_DECODE_ERR_EN
  assign resp_err = r_err;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_master.sv
module tb_io_bus_master;
  localparam logic [31:0] IDLE_A = 32'hFFFF_FFFC;
  localparam logic [31:0] FLOAT  = 32'hFFFF_FFFF;  // pulled-up, undriven bus
  localparam logic [31:0] A_CNT  = 32'hF000_0020;
  localparam logic [31:0] A_LIM  = 32'hF000_0024;

  logic clk, reset;
  logic req_we;
  logic [31:0] req_addr, req_wdata;

  // DUT with WAIT_CYCLES=1
  logic req_valid, req_ready, resp_valid, resp_err, wrten;
  logic [31:0] resp_rdata, abus;
  wire  [31:0] dbus;
  logic dev_en;
  logic [31:0] dev_addr, dev_data;

  // DUT with WAIT_CYCLES=3
  logic req_valid3, req_ready3, resp_valid3, resp_err3, wrten3;
  logic [31:0] resp_rdata3, abus3;
  wire  [31:0] dbus3;
  logic dev_en3;
  logic [31:0] dev_data3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_rdata;   // reference: last load value seen by the W=1 master

  io_bus_master #(.WAIT_CYCLES(1)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .aBus(abus), .dBus(dbus), .wrtEn(wrten));

  io_bus_master #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
    .aBus(abus3), .dBus(dbus3), .wrtEn(wrten3));

  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup (dbus[g]);
    pullup (dbus3[g]);
  end

  // Read-only device models: drive data while addressed and not strobed.
  assign dbus  = (dev_en && (abus == dev_addr) && !wrten) ? dev_data : 'z;
  assign dbus3 = (dev_en3 && (abus3 == A_CNT) && !wrten3) ? dev_data3 : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the W=1 master, started from IDLE. Expected timing is
  // derived from the latency rules: store responds in cycle 3, load in 2+W,
  // out-of-window (when decoding is on) in cycle 1 with no bus activity.
  task automatic run_txn(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdval);
    logic err;
    int lat;
    logic [31:0] exp_d;
`ifdef IO_BUS_MASTER_DECODE_ERR_EN
    err = !((addr >= 32'hF000_0000) && (addr <= 32'hF000_03FF));
`else
    err = 1'b0;
`endif
    lat = err ? 1 : (we ? 3 : 3);
    chk("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    dev_en = !we; dev_addr = addr; dev_data = rdval;
    for (int c = 1; c <= lat + 1; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      if (err)          exp_d = FLOAT;
      else if (we)      exp_d = (c <= 2) ? wdata : FLOAT;
      else              exp_d = (c < lat) ? rdval : FLOAT;
      chk("ready",  32'(req_ready),  32'(c == lat + 1));
      chk("resp_v", 32'(resp_valid), 32'(c == lat));
      chk("wrten",  32'(wrten),      32'(we && !err && c == 2));
      chk("abus",   abus,            (!err && c < lat) ? addr : IDLE_A);
      chk("dbus",   dbus,            exp_d);
      if (c == lat) begin
        if (!we && !err) m_rdata = rdval;
        chk("rdata", resp_rdata, m_rdata);
        chk("err",   32'(resp_err), 32'(err));
      end
    end
    dev_en = 1'b0;
  endtask

  initial begin
    int wr_pulses;
    logic [31:0] v1, v2;
    reset = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; dev_en = 1'b0; dev_addr = '0; dev_data = '0;
    dev_en3 = 1'b0; dev_data3 = '0; m_rdata = '0;
    repeat (2) tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_v", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_abus", abus, IDLE_A);
    chk("rst_wrten", 32'(wrten), 32'd0);
    chk("rst_dbus", dbus, FLOAT);
    reset = 1'b0;
    tick();

    // Directed store and load on the timer registers.
    run_txn(1'b1, A_LIM, 32'h10, 32'h0);
    run_txn(1'b0, A_CNT, 32'h0, 32'hA5);

    // WAIT_CYCLES=3: data changed during cycle 4 is the value captured.
    v1 = $urandom; v2 = ~v1;
    req_valid3 = 1'b1; req_we = 1'b0; req_addr = A_CNT;
    dev_en3 = 1'b1; dev_data3 = v1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req_valid3 = 1'b0;
      chk("w3_resp_v", 32'(resp_valid3), 32'(c == 5));
      chk("w3_ready", 32'(req_ready3), 32'(c == 6));
      chk("w3_abus", abus3, (c <= 4) ? A_CNT : IDLE_A);
      chk("w3_wrten", 32'(wrten3), 32'd0);
      if (c == 3) dev_data3 = v2;
      if (c == 5) begin
        chk("w3_rdata", resp_rdata3, v2);
        chk("w3_err", 32'(resp_err3), 32'd0);
      end
    end
    dev_en3 = 1'b0;

    // req_valid held: store, then load accepted only once the master is idle.
    wr_pulses = 0;
    v1 = $urandom;
    req_valid = 1'b1; req_we = 1'b1; req_addr = A_LIM; req_wdata = 32'h5A5A_0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        req_we = 1'b0; req_addr = A_CNT;
        dev_en = 1'b1; dev_addr = A_CNT; dev_data = v1;
      end
      if (c == 5) req_valid = 1'b0;
      wr_pulses += int'(wrten);
      chk("b2b_ready", 32'(req_ready), 32'(c == 4 || c == 8));
      chk("b2b_resp_v", 32'(resp_valid), 32'(c == 3 || c == 7));
      if (c == 3) chk("b2b_st_rdata", resp_rdata, m_rdata);
      if (c == 5) chk("b2b_ld_abus", abus, A_CNT);
      if (c == 7) begin
        m_rdata = v1;
        chk("b2b_ld_rdata", resp_rdata, m_rdata);
      end
    end
    chk("b2b_wr_pulses", 32'(wr_pulses), 32'd1);
    dev_en = 1'b0;

    // Reset while waiting on a load: abort, no response, bus released.
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_CNT;
    dev_en = 1'b1; dev_addr = A_CNT; dev_data = 32'h1234_5678;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rw_abus_wait", abus, A_CNT);
    reset = 1'b1;
    tick();
    m_rdata = '0;
    chk("rw_resp_v", 32'(resp_valid), 32'd0);
    chk("rw_abus", abus, IDLE_A);
    chk("rw_dbus", dbus, FLOAT);
    chk("rw_ready", 32'(req_ready), 32'd1);
    chk("rw_rdata", resp_rdata, m_rdata);
    reset = 1'b0;
    tick();
    chk("rw_resp_v2", 32'(resp_valid), 32'd0);
    dev_en = 1'b0;

    // Address outside the I/O window.
    run_txn(1'b0, 32'h0000_1000, 32'h0, $urandom);

    // Randomized mix of loads/stores, in and out of the window, with gaps.
    for (int t = 0; t < 24; t++) begin
      logic we;
      logic [31:0] addr;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) addr = $urandom & 32'h0000_FFFC;
      else                           addr = 32'hF000_0000 | ($urandom & 32'h0000_03FC);
      run_txn(we, addr, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("gap_abus", abus, IDLE_A);
        chk("gap_resp_v", 32'(resp_valid), 32'd0);
        chk("gap_wrten", 32'(wrten), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
